// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low {g,f,e,d,c,b,a} patterns,
// slot index type and slot numbering for the 4-digit scanner.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_LO_ONES = 2'd0;
  localparam slot_t SLOT_LO_TENS = 2'd1;
  localparam slot_t SLOT_HI_ONES = 2'd2;
  localparam slot_t SLOT_HI_TENS = 2'd3;

  typedef struct packed {
    logic [3:0] hi_tens;
    logic [3:0] hi_ones;
    logic [3:0] lo_tens;
    logic [3:0] lo_ones;
    logic       blink_hi;
    logic       blink_lo;
  } snap_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; values above 9
// show a dash so a corrupted counter is visible rather than silently wrong.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// 4-digit multiplexed seven-segment driver with per-frame snapshot, pair blink
// and colon dp; one register stage after each tick. Option: LEADING_ZERO_BLANK_EN.
module bcd_display_scanner
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] hi_tens_i,
  input  logic [3:0] hi_ones_i,
  input  logic [3:0] lo_tens_i,
  input  logic [3:0] lo_ones_i,
  input  logic       blink_hi_i,
  input  logic       blink_lo_i,
  input  logic       colon_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic [3:0] an_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic [PW-1:0] pre_cnt;
  logic [FW-1:0] frame_cnt;
  slot_t         slot;
  snap_t         snap;
  logic          phase;
  logic          lit;

  logic          tick;
  logic          frame_start;
  logic          frame_wrap;
  slot_t         nxt_slot;
  snap_t         nxt_snap;
  logic          nxt_phase;
  logic [3:0]    digit;
  logic [6:0]    dec_seg;
  logic          blank;

  assign tick        = (pre_cnt == PW'(SCAN_DIV - 1));
  assign frame_start = tick && (slot == SLOT_HI_TENS);
  assign frame_wrap  = (frame_cnt == FW'(BLINK_FRAMES - 1));

  // Outputs are built from next-state values so a tick is visible one edge later,
  // and a frame start shows slot 0 with the digits captured on that same edge.
  always_comb begin
    nxt_slot  = tick ? slot_t'(slot + 2'd1) : slot;
    nxt_snap  = snap;
    nxt_phase = phase;
    if (frame_start) begin
      nxt_snap = '{hi_tens: hi_tens_i, hi_ones: hi_ones_i,
                   lo_tens: lo_tens_i, lo_ones: lo_ones_i,
                   blink_hi: blink_hi_i, blink_lo: blink_lo_i};
      if (frame_wrap) nxt_phase = ~phase;
    end
  end

  always_comb begin
    digit = nxt_snap.lo_ones;
    case (nxt_slot)
      SLOT_LO_ONES: digit = nxt_snap.lo_ones;
      SLOT_LO_TENS: digit = nxt_snap.lo_tens;
      SLOT_HI_ONES: digit = nxt_snap.hi_ones;
      SLOT_HI_TENS: digit = nxt_snap.hi_tens;
      default:      digit = nxt_snap.lo_ones;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (digit),
    .seg (dec_seg)
  );

  always_comb begin
    blank = (nxt_slot[1] ? nxt_snap.blink_hi : nxt_snap.blink_lo) && !nxt_phase;
`ifdef LEADING_ZERO_BLANK_EN
    if (nxt_slot == SLOT_HI_TENS && nxt_snap.hi_tens == 4'd0) blank = 1'b1;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pre_cnt   <= '0;
      slot      <= SLOT_HI_TENS;
      frame_cnt <= '0;
      phase     <= 1'b1;
      snap      <= '0;
      lit       <= 1'b0;
      seg_o     <= SEG_BLANK;
      dp_o      <= 1'b1;
      an_o      <= 4'b1111;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      slot    <= nxt_slot;
      snap    <= nxt_snap;
      phase   <= nxt_phase;
      if (frame_start) frame_cnt <= frame_wrap ? '0 : frame_cnt + FW'(1);
      if (tick) lit <= 1'b1;
      // Stay dark until the first tick has selected a real slot.
      if (tick || lit) begin
        seg_o <= blank ? SEG_BLANK : dec_seg;
        an_o  <= ~(4'b0001 << nxt_slot);
        dp_o  <= !(nxt_slot == SLOT_HI_ONES && colon_i && nxt_phase);
      end else begin
        seg_o <= SEG_BLANK;
        an_o  <= 4'b1111;
        dp_o  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with a cycle-count display model.
module tb_bcd_display_scanner;

  localparam int SD = 4;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [3:0] hi_tens_i, hi_ones_i, lo_tens_i, lo_ones_i;
  logic       blink_hi_i, blink_lo_i, colon_i;
  logic [6:0] seg_o;
  logic       dp_o;
  logic [3:0] an_o;

  bcd_display_scanner #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .hi_tens_i  (hi_tens_i),
    .hi_ones_i  (hi_ones_i),
    .lo_tens_i  (lo_tens_i),
    .lo_ones_i  (lo_ones_i),
    .blink_hi_i (blink_hi_i),
    .blink_lo_i (blink_lo_i),
    .colon_i    (colon_i),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .an_o       (an_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: n = edges since reset released; everything derives from n.
  int         n = 0;
  logic [3:0] s_ht, s_ho, s_lt, s_lo;
  logic       s_bh, s_bl;
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic [3:0] exp_an;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic model_edge();
    int ticks, slot, fs;
    logic ph, blank;
    logic [3:0] d;
    if (reset_i) begin
      n = 0;
      {s_ht, s_ho, s_lt, s_lo, s_bh, s_bl} = '0;
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF;
    end else begin
      n++;
      ticks = n / SD;
      if (n % SD == 0 && (ticks - 1) % 4 == 0) begin
        s_ht = hi_tens_i; s_ho = hi_ones_i; s_lt = lo_tens_i; s_lo = lo_ones_i;
        s_bh = blink_hi_i; s_bl = blink_lo_i;
      end
      if (ticks == 0) begin
        exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF;
      end else begin
        slot = (ticks - 1) % 4;
        fs   = (ticks - 1) / 4 + 1;
        ph   = ((fs / BF) % 2) == 0;
        case (slot)
          0: d = s_lo;
          1: d = s_lt;
          2: d = s_ho;
          default: d = s_ht;
        endcase
        blank = ((slot < 2) ? s_bl : s_bh) && !ph;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot == 3 && s_ht == 4'd0) blank = 1'b1;
`endif
        exp_seg = blank ? 7'h7F : seg_of(d);
        exp_an  = 4'hF & ~(4'h1 << slot);
        exp_dp  = !(slot == 2 && colon_i && ph);
      end
    end
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      vectors++;
      if ({seg_o, dp_o, an_o} !== {exp_seg, exp_dp, exp_an}) begin
        miscompares++;
        $display("FAIL model n=%0d: seg/dp/an got %b/%b/%b want %b/%b/%b",
                 n, seg_o, dp_o, an_o, exp_seg, exp_dp, exp_an);
      end
    end
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %b want %b", name, act, want);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    hi_tens_i = 4'd1; hi_ones_i = 4'd2; lo_tens_i = 4'd3; lo_ones_i = 4'd4;
    blink_hi_i = 1'b0; blink_lo_i = 1'b0; colon_i = 1'b0;
    run(3);
    chk("reset_dark", {seg_o, dp_o, an_o}, {7'h7F, 1'b1, 4'b1111});
    reset_i = 1'b0;
    run(3);
    chk("pre_tick_dark", {8'h0, an_o}, {8'h0, 4'b1111});
    run(1);
    chk("slot0_4", {1'b0, seg_o, an_o}, {1'b0, 7'b0011001, 4'b1110});
    run(4);
    chk("slot1_3", {1'b0, seg_o, an_o}, {1'b0, 7'b0110000, 4'b1101});
    run(4);
    chk("slot2_2", {1'b0, seg_o, an_o}, {1'b0, 7'b0100100, 4'b1011});
    run(4);
    chk("slot3_1", {1'b0, seg_o, an_o}, {1'b0, 7'b1111001, 4'b0111});
    run(8);                                  // now in slot 1 of frame 2
    lo_ones_i = 4'd7;
    run(12);
    chk("snap_new_7", {1'b0, seg_o, an_o}, {1'b0, 7'b1111000, 4'b1110});
    lo_tens_i = 4'hC; blink_lo_i = 1'b1; colon_i = 1'b1;
    run(20);
    chk("dash", {1'b0, seg_o, an_o}, {1'b0, 7'b0111111, 4'b1101});
    run(28);
    chk("blink_blank", {1'b0, seg_o, an_o}, {1'b0, 7'h7F, 4'b1110});
    run(8);
    chk("hi_unblinked_dp_off", {seg_o, dp_o, an_o}, {7'b0100100, 1'b1, 4'b1011});
    run(32);
    chk("colon_on", {seg_o, dp_o, an_o}, {7'b0100100, 1'b0, 4'b1011});
    hi_tens_i = 4'd0;
    run(20);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lead_zero", {1'b0, seg_o, an_o}, {1'b0, 7'h7F, 4'b0111});
`else
    chk("lead_zero", {1'b0, seg_o, an_o}, {1'b0, 7'b1000000, 4'b0111});
`endif
    run(12);
    chk("pre_reset_slot2", {8'h0, an_o}, {8'h0, 4'b1011});
    reset_i = 1'b1;
    run(1);
    chk("midframe_reset_dark", {seg_o, dp_o, an_o}, {7'h7F, 1'b1, 4'b1111});
    reset_i = 1'b0;
    run(3);
    chk("restart_dark", {8'h0, an_o}, {8'h0, 4'b1111});
    run(1);
    chk("restart_slot0", {1'b0, seg_o, an_o}, {1'b0, 7'b1111000, 4'b1110});
    hi_ones_i = 4'd9; blink_hi_i = 1'b1; blink_lo_i = 1'b0; lo_tens_i = 4'd5;
    run(48);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
